// File: rtl/vga_sync_decoder.sv
// Receive-side VGA decoder: recovers pixel x/y/colour from the TinyVGA PMOD byte, verifies line/frame timing, signs each frame.
// Latency 3 clk vga_in->px_*, no backpressure (free-running video). VGA_DEC_CRC_EN selects a CRC-16/CCITT signature over a plain sum.
module vga_sync_decoder #(
    parameter int H_DISPLAY   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_DISPLAY   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [5:0]  px_rgb,
    output logic        locked,
    output logic        timing_err,
    output logic        frame_done,
    output logic [15:0] frame_sig
);
    localparam logic        SYNC_LVL = (SYNC_ACTIVE != 0);
    localparam logic [9:0]  H_ACT0   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_ACT1   = 10'(H_SYNC + H_BACK + H_DISPLAY);
    // Line count lags the generator by one because it advances mid-line from our point of view.
    localparam logic [9:0]  V_ACT0   = 10'(V_SYNC + V_BACK - 1);
    localparam logic [9:0]  V_ACT1   = 10'(V_SYNC + V_BACK - 1 + V_DISPLAY);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL);
    localparam logic [10:0] H_PER    = 11'(H_TOTAL);
    localparam logic [9:0]  V_LINES  = 10'(V_TOTAL);
    localparam logic [9:0]  X_LAST   = 10'(H_DISPLAY - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_DISPLAY - 1);

`ifdef VGA_DEC_CRC_EN
    localparam logic [15:0] SIG_INIT = 16'hFFFF;

    function automatic logic [15:0] sig_step(input logic [15:0] crc, input logic [5:0] rgb);
        logic [15:0] r;
        r = crc ^ {2'b00, rgb, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction
`else
    localparam logic [15:0] SIG_INIT = 16'h0000;

    function automatic logic [15:0] sig_step(input logic [15:0] acc, input logic [5:0] rgb);
        return acc + {10'b0, rgb};
    endfunction
`endif

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_next;
    logic [7:0]  s1, s2;
    logic        hs_edge, vs_edge;
    logic [9:0]  h_cnt, v_cnt, line_cnt, line_base;
    logic        vs_pend;
    logic [10:0] h_period, h_len;
    logic        in_window, err;
    logic [15:0] sig_acc, sig_base, sig_next;

    assign hs_edge   = (s1[7] == SYNC_LVL) && (s2[7] != SYNC_LVL);
    assign vs_edge   = (s1[3] == SYNC_LVL) && (s2[3] != SYNC_LVL);
    assign h_len     = {1'b0, h_cnt} + 11'd1;
    assign line_base = vs_edge ? 10'd0 : line_cnt;
    assign in_window = locked && (h_cnt >= H_ACT0) && (h_cnt < H_ACT1)
                              && (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
    assign sig_base  = vs_edge ? SIG_INIT : sig_acc;
    assign sig_next  = px_valid ? sig_step(sig_base, px_rgb) : sig_base;

    always_comb begin
        state_next = state;
        err        = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_edge) state_next = MEASURE;
            end
            MEASURE: begin
                if (vs_edge && (h_period == H_PER) && (line_cnt == V_LINES)) state_next = LOCKED;
            end
            LOCKED: begin
                err = (hs_edge && (h_len != H_PER)) || (h_cnt == H_LAST)
                   || (vs_edge && (line_cnt != V_LINES));
                if (err) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            s1         <= '0;
            s2         <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            vs_pend    <= 1'b0;
            line_cnt   <= '0;
            h_period   <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
            px_valid   <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_rgb     <= '0;
            sig_acc    <= '0;
            frame_sig  <= '0;
            frame_done <= 1'b0;
        end else begin
            s1 <= vga_in;
            s2 <= s1;

            if (hs_edge)           h_cnt <= '0;
            else if (h_cnt != '1)  h_cnt <= h_cnt + 10'd1;

            // A vsync seen this cycle counts as pending, so a coincident hsync starts line 0.
            if (hs_edge) begin
                h_period <= h_len;
                if (vs_pend || vs_edge) begin
                    v_cnt   <= '0;
                    vs_pend <= 1'b0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else if (vs_edge) begin
                vs_pend <= 1'b1;
            end

            line_cnt   <= (hs_edge && (line_base != '1)) ? line_base + 10'd1 : line_base;
            state      <= state_next;
            locked     <= (state_next == LOCKED);
            timing_err <= err;

            px_valid <= in_window;
            if (in_window) begin
                px_x   <= h_cnt - H_ACT0;
                px_y   <= v_cnt - V_ACT0;
                px_rgb <= {s2[0], s2[4], s2[1], s2[5], s2[2], s2[6]};
            end

            sig_acc    <= sig_next;
            frame_done <= 1'b0;
            if (locked && px_valid && (px_x == X_LAST) && (px_y == Y_LAST)) begin
                frame_sig  <= sig_next;
                frame_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced 16x12 raster so whole frames run quickly.
// A per-frame table drives a raster generator; expected pixels come from the generator through a 3-deep delay queue.
module tb_vga_sync_decoder;
    localparam int H_DISPLAY = 8, H_SYNC = 2, H_BACK = 3, H_TOTAL = 16;
    localparam int V_DISPLAY = 5, V_SYNC = 2, V_BACK = 3, V_TOTAL = 12;
    localparam int H_FP = H_TOTAL - H_DISPLAY - H_SYNC - H_BACK;
    localparam int V_FP = V_TOTAL - V_DISPLAY - V_SYNC - V_BACK;
    localparam logic SYNC_ON = 1'b0;

`ifdef VGA_DEC_CRC_EN
    localparam logic [15:0] SIG_INIT = 16'hFFFF;
`else
    localparam logic [15:0] SIG_INIT = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  vga_in = 8'h88;
    logic        px_valid, locked, timing_err, frame_done;
    logic [9:0]  px_x, px_y;
    logic [5:0]  px_rgb;
    logic [15:0] frame_sig;

    vga_sync_decoder #(
        .H_DISPLAY(H_DISPLAY), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
        .V_DISPLAY(V_DISPLAY), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL),
        .SYNC_ACTIVE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .locked(locked), .timing_err(timing_err), .frame_done(frame_done), .frame_sig(frame_sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       act;
        int         x;
        int         y;
        logic [5:0] rgb;
    } pix_t;

    typedef struct {
        int lines;      // raster lines generated this frame
        int short_line; // line cut to H_TOTAL-1 clocks, -1 none
        int nohs_line;  // line whose hsync pulse is suppressed, -1 none
        int rst_line;   // line at which rst_n is pulsed low for 5 clocks, -1 none
        int mode;       // 0 solid 111000, 1 x^y, 2 random
        int exp_err;    // timing_err pulses expected this frame
        bit exp_lock;   // locked at end of frame
        bit chk;        // decoder expected locked over the active area
    } row_t;

    int checks = 0, errors = 0;
    int step_cnt = 0, rst_cnt = 0;
    int err_seen, done_seen, valid_seen, last_err_step, locked_at_err, done_due;
    bit chk_en = 1'b0, have_last;
    int last_x, last_y, last_rgb;
    logic last_locked;
    logic [15:0] model_sig;
    pix_t pipe[$];
    row_t tbl[15];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp, step_cnt);
        end
    endfunction

    function automatic logic [15:0] sig_add(input logic [15:0] a, input logic [5:0] rgb);
        logic [15:0] r;
`ifdef VGA_DEC_CRC_EN
        logic [7:0] d;
        logic       fb;
        r = a;
        d = {2'b00, rgb};
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
`else
        r = a + {10'd0, rgb};
`endif
        return r;
    endfunction

    // One pixel clock: sample outputs on the falling edge, then drive the next byte.
    task automatic step(input logic [7:0] b, input pix_t p);
        pix_t e;
        @(negedge clk);
        if (timing_err) begin
            err_seen++;
            last_err_step = step_cnt;
            locked_at_err = int'(locked);
        end
        if (frame_done) done_seen++;
        if (px_valid) valid_seen++;
        last_locked = locked;
        if (!rst_n) begin
            chk("reset px outputs", int'({px_valid, px_x, px_y, px_rgb}), 0);
            chk("reset status outputs", int'({locked, timing_err, frame_done}), 0);
            chk("reset frame_sig", int'(frame_sig), 0);
        end
        if (pipe.size() == 3) begin
            e = pipe.pop_front();
            if (chk_en) begin
                chk("px_valid", int'(px_valid), int'(e.act));
                if (e.act) begin
                    chk("px_x", int'(px_x), e.x);
                    chk("px_y", int'(px_y), e.y);
                    chk("px_rgb", int'(px_rgb), int'(e.rgb));
                    last_x = e.x; last_y = e.y; last_rgb = int'(e.rgb);
                    have_last = 1'b1;
                    if (e.x == H_DISPLAY - 1 && e.y == V_DISPLAY - 1) done_due = step_cnt + 1;
                end else if (have_last) begin
                    chk("px_x hold", int'(px_x), last_x);
                    chk("px_y hold", int'(px_y), last_y);
                    chk("px_rgb hold", int'(px_rgb), last_rgb);
                end
                chk("frame_done timing", int'(frame_done), int'(step_cnt == done_due));
                if (frame_done) chk("frame_sig", int'(frame_sig), int'(model_sig));
            end
        end
        if (rst_cnt > 0) begin
            rst_n = 1'b0;
            rst_cnt--;
        end else begin
            rst_n = 1'b1;
        end
        vga_in = b;
        pipe.push_back(p);
        step_cnt++;
    endtask

    task automatic gen_frame(input row_t r);
        int len, gx, exp_err_step;
        logic hs, vs;
        logic [5:0] c;
        pix_t p;
        err_seen = 0; done_seen = 0; valid_seen = 0; last_err_step = -1; locked_at_err = -1;
        done_due = -10; have_last = 1'b0; chk_en = r.chk; model_sig = SIG_INIT; exp_err_step = -1;
        for (int gy = 0; gy < r.lines; gy++) begin
            len = (gy == r.short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int cc = 0; cc < len; cc++) begin
                gx = (cc < H_DISPLAY || len == H_TOTAL) ? cc : cc + 1;
                if (gy == r.rst_line && cc == 0) rst_cnt = 5;
                hs = (gx >= H_DISPLAY + H_FP && gx < H_DISPLAY + H_FP + H_SYNC && gy != r.nohs_line)
                     ? SYNC_ON : ~SYNC_ON;
                vs = (gy >= V_DISPLAY + V_FP && gy < V_DISPLAY + V_FP + V_SYNC) ? SYNC_ON : ~SYNC_ON;
                p.act = (gx < H_DISPLAY) && (gy < V_DISPLAY);
                p.x = gx; p.y = gy;
                case (r.mode)
                    0:       c = 6'b111000;
                    1:       c = 6'(gx ^ gy);
                    default: c = 6'($urandom_range(63, 0));
                endcase
                if (!p.act) c = 6'd0;
                p.rgb = c;
                if (p.act) model_sig = sig_add(model_sig, c);
                if (gx == H_DISPLAY + H_FP) begin
                    if (gy == r.short_line)    exp_err_step = step_cnt + 2;
                    if (gy == r.nohs_line - 1) exp_err_step = step_cnt + H_TOTAL + 3;
                end
                step({hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]}, p);
            end
        end
        chk("timing_err pulses", err_seen, r.exp_err);
        if (r.exp_err > 0) begin
            chk("timing_err step", last_err_step, exp_err_step);
            chk("locked with timing_err", locked_at_err, 0);
        end
        chk("locked at frame end", int'(last_locked), int'(r.exp_lock));
        if (r.chk) begin
            chk("px_valid count", valid_seen, H_DISPLAY * V_DISPLAY);
            chk("frame_done count", done_seen, 1);
        end
    endtask

    initial begin
        //          lines short nohs rst mode err lock chk
        tbl[0]  = '{12, -1, -1, -1, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{12, -1, -1, -1, 0, 0, 1'b1, 1'b0};
        tbl[2]  = '{12, -1, -1, -1, 0, 0, 1'b1, 1'b1};
        tbl[3]  = '{12, -1, -1, -1, 1, 0, 1'b1, 1'b1};
        tbl[4]  = '{12, -1, -1, -1, 2, 0, 1'b1, 1'b1};
        tbl[5]  = '{12,  5, -1, -1, 2, 1, 1'b0, 1'b1};
        tbl[6]  = '{12, -1, -1, -1, 2, 0, 1'b1, 1'b0};
        tbl[7]  = '{12, -1, -1, -1, 1, 0, 1'b1, 1'b1};
        tbl[8]  = '{11, -1,  5, -1, 2, 1, 1'b0, 1'b1};
        tbl[9]  = '{12, -1, -1, -1, 2, 0, 1'b0, 1'b0};
        tbl[10] = '{12, -1, -1, -1, 2, 0, 1'b1, 1'b0};
        tbl[11] = '{12, -1, -1, -1, 2, 0, 1'b1, 1'b1};
        tbl[12] = '{12, -1, -1,  2, 0, 0, 1'b0, 1'b0};
        tbl[13] = '{12, -1, -1, -1, 1, 0, 1'b1, 1'b0};
        tbl[14] = '{12, -1, -1, -1, 2, 0, 1'b1, 1'b1};

        #2 rst_n = 1'b0;
        rst_cnt = 5;
        #1;
        chk("initial px outputs", int'({px_valid, px_x, px_y, px_rgb}), 0);
        chk("initial status outputs", int'({locked, timing_err, frame_done}), 0);
        chk("initial frame_sig", int'(frame_sig), 0);

        for (int i = 0; i < 15; i++) gen_frame(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
